// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared definitions for the boot-time program loader
// and the program memory write side (loader FSM states, write-enable codes).
package program_loader_pkg;

  // Loader FSM states. CSUM is only reachable when PROG_LOADER_CHECKSUM_EN
  // is defined; the encoding is shared so debug tooling sees one layout.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_LO   = 3'd2,
    ST_HI   = 3'd3,
    ST_WR   = 3'd4,
    ST_CSUM = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  // Byte-lane write enables for the 16-bit program memory.
  localparam logic [1:0] WE_WORD = 2'b11;
  localparam logic [1:0] WE_NONE = 2'b00;

  // States in which the loader takes bytes from the stream.
  function automatic logic accepts_bytes(input state_t s);
    return (s == ST_LEN) || (s == ST_LO) || (s == ST_HI) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/program_loader.sv
// program_loader: boot-time writer for the 256x16 program memory.
// Takes a byte stream (count byte N, then N+1 little-endian words, then an
// optional checksum byte), writes one word per WR cycle and holds the CPU
// off until a complete image is in memory.
//
// Optional feature macro: PROG_LOADER_CHECKSUM_EN
//   defined   : running XOR over count + data bytes, compared against a
//               trailing checksum byte in CSUM; mismatch sets error and
//               keeps cpu_hold high.
//   undefined : no checksum byte, WR goes straight to DONE, error is 0.
//
// Handshake: a byte transfers on a rising clk edge where in_valid && in_ready.
// in_ready is a registered decode of the state (high in LEN/LO/HI/CSUM), so
// the source may hold or drop in_valid for any number of cycles; nothing is
// consumed while in_ready is low, and in_valid is ignored in IDLE/WR/DONE.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic [1:0]        we,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold,
  output logic [2:0]        state_dbg
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_t      state;
  state_t      state_n;

  logic [7:0]  word_cnt;   // N from the count byte (words minus one)
  logic [7:0]  word_idx;   // index of the word currently being assembled
  logic [7:0]  lo_byte;    // low byte staged until the high byte arrives

  logic        accept;
  logic        last_word;
  logic        load_start;
  logic        enter_done;
  logic        err_n;      // error value latched on the edge entering DONE

  assign accept     = in_valid && in_ready;
  assign last_word  = (word_idx == word_cnt);
  assign load_start = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign enter_done = (state_n == ST_DONE) && (state != ST_DONE);
  assign state_dbg  = state;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state decode; start is only honoured in IDLE/DONE.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (start) state_n = ST_LEN;
      end
      ST_LEN: begin
        if (accept) state_n = ST_LO;
      end
      ST_LO: begin
        if (accept) state_n = ST_HI;
      end
      ST_HI: begin
        if (accept) state_n = ST_WR;
      end
      ST_WR: begin
        if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_n = ST_CSUM;
`else
          state_n = ST_DONE;
`endif
        end else begin
          state_n = ST_LO;
        end
      end
      ST_CSUM: begin
`ifdef PROG_LOADER_CHECKSUM_EN
        if (accept) state_n = ST_DONE;
`else
        state_n = ST_IDLE;
`endif
      end
      ST_DONE: begin
        if (start) state_n = ST_LEN;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Registered handshake outputs decoded from the next state, so in_ready and
  // we line up exactly with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b0;
      we       <= WE_NONE;
    end else begin
      in_ready <= accepts_bytes(state_n);
      we       <= (state_n == ST_WR) ? WE_WORD : WE_NONE;
    end
  end

  // Word assembly and address walk. wr_data is only updated on the edge that
  // enters WR so the memory sees a whole, stable word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr  <= BASE;
      wr_data  <= 16'h0000;
      word_cnt <= 8'h00;
      word_idx <= 8'h00;
      lo_byte  <= 8'h00;
    end else begin
      if (load_start) begin
        wr_addr  <= BASE;
        word_idx <= 8'h00;
      end else begin
        case (state)
          ST_LEN: begin
            if (accept) word_cnt <= in_data;
          end
          ST_LO: begin
            if (accept) lo_byte <= in_data;
          end
          ST_HI: begin
            if (accept) wr_data <= {in_data, lo_byte};
          end
          ST_WR: begin
            if (!last_word) begin
              wr_addr  <= wr_addr + ADDR_W'(1);
              word_idx <= word_idx + 8'd1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  assign err_n = (state == ST_CSUM) && (in_data != csum);

  // Running XOR over the count byte and every data byte of the image.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum <= 8'h00;
    end else if (load_start) begin
      csum <= 8'h00;
    end else if (accept && ((state == ST_LEN) || (state == ST_LO) || (state == ST_HI))) begin
      csum <= csum ^ in_data;
    end
  end

  // Error flag: cleared by start, latched from the checksum compare on DONE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error <= 1'b0;
    end else if (load_start) begin
      error <= 1'b0;
    end else if (enter_done) begin
      error <= err_n;
    end
  end
`else
  assign err_n = 1'b0;
  assign error = 1'b0;
`endif

  // Load status: busy/cpu_hold rise on start; done rises and cpu_hold follows
  // the error result on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      cpu_hold <= 1'b1;
    end else if (load_start) begin
      busy     <= 1'b1;
      done     <= 1'b0;
      cpu_hold <= 1'b1;
    end else if (enter_done) begin
      busy     <= 1'b0;
      done     <= 1'b1;
      cpu_hold <= err_n;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: self-checking bench for program_loader. Two instances
// share one byte stream: BASE_ADDR=0 and BASE_ADDR=F0. Expected writes come
// from the image itself: word i lands at (BASE + i) mod 256.
module tb_program_loader;
  import program_loader_pkg::*;

  typedef logic [23:0] ent_t;   // {addr, data}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start;
  logic       in_valid;
  logic [7:0] in_data;

  logic        a_in_ready, a_busy, a_done, a_error, a_cpu_hold;
  logic [7:0]  a_wr_addr;
  logic [15:0] a_wr_data;
  logic [1:0]  a_we;
  logic [2:0]  a_state;
  logic        b_in_ready, b_busy, b_done, b_error, b_cpu_hold;
  logic [7:0]  b_wr_addr;
  logic [15:0] b_wr_data;
  logic [1:0]  b_we;
  logic [2:0]  b_state;

  program_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(a_in_ready), .wr_addr(a_wr_addr),
    .wr_data(a_wr_data), .we(a_we), .busy(a_busy), .done(a_done),
    .error(a_error), .cpu_hold(a_cpu_hold), .state_dbg(a_state)
  );

  program_loader #(.ADDR_W(8), .BASE_ADDR(8'hF0)) dut_f0 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(b_in_ready), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .we(b_we), .busy(b_busy), .done(b_done),
    .error(b_error), .cpu_hold(b_cpu_hold), .state_dbg(b_state)
  );

  // ---------------- scoreboard ----------------
  int   checks;
  int   failures;
  ent_t exp_q[$];
  ent_t exp_b_q[$];
  logic [15:0] img[256];

  // Advance to the next falling edge and score any write seen there.
  task automatic tick();
    ent_t got;
    ent_t e;
    @(negedge clk);
    if (a_we !== WE_NONE) begin
      checks++;
      if (a_we !== WE_WORD || exp_q.size() == 0) begin
        failures++;
        $display("FAIL write_a: we=%b pending=%0d, required we=11 with a queued word", a_we, exp_q.size());
      end else begin
        got = {a_wr_addr, a_wr_data};
        e = exp_q.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL write_a: got addr=%h data=%h, required addr=%h data=%h", got[23:16], got[15:0], e[23:16], e[15:0]);
        end
      end
      checks++;
      if (a_in_ready !== 1'b0) begin
        failures++;
        $display("FAIL ready_in_wr_a: in_ready=%b, required 0", a_in_ready);
      end
    end
    if (b_we !== WE_NONE) begin
      checks++;
      if (b_we !== WE_WORD || exp_b_q.size() == 0) begin
        failures++;
        $display("FAIL write_b: we=%b pending=%0d, required we=11 with a queued word", b_we, exp_b_q.size());
      end else begin
        got = {b_wr_addr, b_wr_data};
        e = exp_b_q.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL write_b: got addr=%h data=%h, required addr=%h data=%h", got[23:16], got[15:0], e[23:16], e[15:0]);
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one byte after a random gap and hold it until it is taken.
  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int cnt;
    repeat ($urandom_range(0, gap_max)) tick();
    in_valid = 1'b1;
    in_data  = b;
    cnt = 0;
    while (a_in_ready !== 1'b1 && cnt < 50) begin
      tick();
      cnt++;
    end
    if (a_in_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: in_ready=%b after %0d cycles, required 1", a_in_ready, cnt);
    end else begin
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Stream img[0..n-1] (plus checksum when built), then check the end state.
  // glitch_idx >= 0 pulses start just before that byte index is sent.
  task automatic stream_image(input int n, input int gap_max, input bit bad_csum, input int glitch_idx);
    logic [7:0] bytes[$];
    logic [7:0] x;
    logic [7:0] ai;
    logic [7:0] last_a;
    bit         exp_err;
    int         cnt;
    x = 8'(n - 1);
    bytes.push_back(x);
    for (int i = 0; i < n; i++) begin
      ai = 8'(i);
      bytes.push_back(img[i][7:0]);
      bytes.push_back(img[i][15:8]);
      exp_q.push_back({ai, img[i]});
      exp_b_q.push_back({ai + 8'hF0, img[i]});
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    x = 8'h00;
    foreach (bytes[k]) x = x ^ bytes[k];
    bytes.push_back(bad_csum ? (x ^ 8'h01) : x);
    exp_err = bad_csum;
`else
    exp_err = 1'b0;
`endif
    foreach (bytes[k]) begin
      if (k == glitch_idx) pulse_start();
      send_byte(bytes[k], gap_max);
    end
    cnt = 0;
    while (a_done !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    last_a = 8'(n - 1);
    checks++;
    if (a_done !== 1'b1 || a_busy !== 1'b0) begin
      failures++;
      $display("FAIL done_a n=%0d: done=%b busy=%b, required done=1 busy=0", n, a_done, a_busy);
    end
    checks++;
    if (a_error !== exp_err || a_cpu_hold !== exp_err) begin
      failures++;
      $display("FAIL status_a n=%0d: error=%b cpu_hold=%b, required %b %b", n, a_error, a_cpu_hold, exp_err, exp_err);
    end
    checks++;
    if (b_done !== 1'b1 || b_cpu_hold !== exp_err) begin
      failures++;
      $display("FAIL done_b n=%0d: done=%b cpu_hold=%b, required 1 %b", n, b_done, b_cpu_hold, exp_err);
    end
    checks++;
    if (exp_q.size() != 0 || exp_b_q.size() != 0) begin
      failures++;
      $display("FAIL missing_writes n=%0d: pending a=%0d b=%0d, required 0 0", n, exp_q.size(), exp_b_q.size());
    end
    checks++;
    if (a_wr_addr !== last_a || b_wr_addr !== (last_a + 8'hF0)) begin
      failures++;
      $display("FAIL final_addr n=%0d: a=%h b=%h, required a=%h b=%h", n, a_wr_addr, b_wr_addr, last_a, last_a + 8'hF0);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (3) tick();
    checks++;
    if (a_in_ready !== 1'b0 || a_we !== 2'b00 || a_busy !== 1'b0 || a_done !== 1'b0 ||
        a_error !== 1'b0 || a_cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL reset_ctrl: rdy=%b we=%b busy=%b done=%b err=%b hold=%b, required 0 00 0 0 0 1",
               a_in_ready, a_we, a_busy, a_done, a_error, a_cpu_hold);
    end
    checks++;
    if (a_wr_addr !== 8'h00 || a_wr_data !== 16'h0000 || b_wr_addr !== 8'hF0) begin
      failures++;
      $display("FAIL reset_data: a_addr=%h data=%h b_addr=%h, required 00 0000 f0", a_wr_addr, a_wr_data, b_wr_addr);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_one_word();
    img[0] = 16'h1234;
    pulse_start();
    stream_image(1, 0, 1'b0, -1);
  endtask

  task automatic test_three_word_gaps();
    img[0] = 16'h0001;
    img[1] = 16'h0002;
    img[2] = 16'h0003;
    pulse_start();
    stream_image(3, 4, 1'b0, -1);
  endtask

  task automatic test_random_loads();
    int n;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) img[i] = 16'($urandom);
      pulse_start();
      stream_image(n, 2, 1'b0, -1);
    end
  endtask

  task automatic test_full_256();
    for (int i = 0; i < 256; i++) img[i] = 16'($urandom);
    pulse_start();
    stream_image(256, 0, 1'b0, -1);
  endtask

  task automatic test_start_during_hi();
    img[0] = 16'hBEEF;
    img[1] = 16'hCAFE;
    pulse_start();
    // byte index 2 is the high byte of word 0, so the loader sits in HI
    stream_image(2, 1, 1'b0, 2);
  endtask

  task automatic test_start_in_done();
    checks++;
    if (a_done !== 1'b1) begin
      failures++;
      $display("FAIL pre_restart: done=%b, required 1", a_done);
    end
    pulse_start();
    checks++;
    if (a_done !== 1'b0 || a_cpu_hold !== 1'b1 || a_busy !== 1'b1) begin
      failures++;
      $display("FAIL restart: done=%b hold=%b busy=%b, required 0 1 1", a_done, a_cpu_hold, a_busy);
    end
    img[0] = 16'h5A5A;
    stream_image(1, 1, 1'b0, -1);
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    send_byte(8'h01, 0);   // two-word image
    send_byte(8'h77, 0);   // low byte of word 0, nothing queued: no write allowed
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_in_ready !== 1'b0 || a_we !== 2'b00 || a_busy !== 1'b0 || a_done !== 1'b0 ||
        a_cpu_hold !== 1'b1 || a_wr_addr !== 8'h00 || a_wr_data !== 16'h0000) begin
      failures++;
      $display("FAIL mid_reset: rdy=%b we=%b busy=%b done=%b hold=%b addr=%h data=%h, required 0 00 0 0 1 00 0000",
               a_in_ready, a_we, a_busy, a_done, a_cpu_hold, a_wr_addr, a_wr_data);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    img[0] = 16'h0F0F;
    img[1] = 16'hF0F0;
    pulse_start();
    stream_image(2, 1, 1'b0, -1);
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    img[0] = 16'h1234;
    pulse_start();
    stream_image(1, 0, 1'b0, -1);   // checksum 26
    pulse_start();
    stream_image(1, 0, 1'b1, -1);   // checksum 27
    for (int i = 0; i < 5; i++) img[i] = 16'($urandom);
    pulse_start();
    stream_image(5, 2, 1'b1, -1);
    pulse_start();
    stream_image(5, 2, 1'b0, -1);
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_one_word();
    test_three_word_gaps();
    test_random_loads();
    test_full_256();
    test_start_during_hi();
    test_start_in_done();
    test_reset_mid_load();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
